ahb_burst_master: RTL and testbench

Parametrised AHB-Lite master engine that turns one command-port request (`start` plus address, size, burst, direction) into a complete pipelined AHB-Lite transaction: single, fixed-length incrementing or wrapping bursts. It generates per-byte write-data check bits, returns read data beat by beat and aborts on an ERROR response. It sits between the test or command driver and the AHB-Lite slave, and is the bus-side counterpart of the driver/monitor interface signals.

---
 rtl/ahb_burst_master.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ahb_burst_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : ahb_burst_master
// Description : AHB-Lite master engine. Turns one command-port request into
//               a pipelined single, incrementing or wrapping burst. Generates
//               per-byte odd-parity check bits for write data, returns read
//               data beat by beat, and abandons the burst on an ERROR
//               response.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_burst_master #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   addr_ip,
    input  logic [2:0]              hsize_ip,
    input  logic [2:0]              hburst_ip,
    input  logic                    hwrite_ip,
    input  logic [DATA_WIDTH-1:0]   data_ip,
    input  logic                    HREADY,
    input  logic                    HRSP,
    input  logic [DATA_WIDTH-1:0]   HRDATA,
    output logic [ADDR_WIDTH-1:0]   HADDR,
    output logic [1:0]              HTRANS,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [DATA_WIDTH-1:0]   HWDATA,
    output logic [DATA_WIDTH/8-1:0] HWDATACHK,
    output logic                    wdata_ack,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rdata_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         c_NUM_LANES  = DATA_WIDTH / 8;
    localparam logic [7:0] c_BUS_BYTES  = 8'(DATA_WIDTH / 8);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ADDR    = 3'd1;
    localparam logic [2:0] c_ST_BURST   = 3'd2;
    localparam logic [2:0] c_ST_LAST    = 3'd3;
    localparam logic [2:0] c_ST_ERR     = 3'd4;

    localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_TRANS_SEQ    = 2'b11;

    // Number of beats for each HBURST code (INCR is treated as one beat).
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst)
            3'b000, 3'b001: burst_beats = 5'd1;
            3'b010, 3'b011: burst_beats = 5'd4;
            3'b100, 3'b101: burst_beats = 5'd8;
            default:        burst_beats = 5'd16;
        endcase
    endfunction

    // log2 of the beat count, used to size the wrap block.
    function automatic logic [2:0] burst_shift(input logic [2:0] burst);
        case (burst)
            3'b000, 3'b001: burst_shift = 3'd0;
            3'b010, 3'b011: burst_shift = 3'd2;
            3'b100, 3'b101: burst_shift = 3'd3;
            default:        burst_shift = 3'd4;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]              r_state;
    logic [ADDR_WIDTH-1:0]   r_haddr;
    logic                    r_hwrite;
    logic [2:0]              r_hsize;
    logic [2:0]              r_hburst;
    logic [ADDR_WIDTH-1:0]   r_wrap_mask;
    logic [4:0]              r_beats_left;
    logic [DATA_WIDTH-1:0]   r_hwdata;
    logic [c_NUM_LANES-1:0]  r_hwdatachk;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_rdata_valid;
    logic                    r_done;
    logic                    r_err;

    // ------------------------------------------------------------------------
    // Request decode (evaluated against the command port while idle)
    // ------------------------------------------------------------------------
    logic [7:0]              w_req_bytes;
    logic                    w_req_legal;
    logic                    w_req_wrap;
    logic [ADDR_WIDTH-1:0]   w_req_incr;
    logic [ADDR_WIDTH-1:0]   w_req_addr;
    logic [ADDR_WIDTH-1:0]   w_req_mask;

    assign w_req_bytes = 8'd1 << hsize_ip;
    assign w_req_legal = (w_req_bytes <= c_BUS_BYTES);
    assign w_req_wrap  = (hburst_ip == 3'b010) || (hburst_ip == 3'b100) ||
                         (hburst_ip == 3'b110);
    assign w_req_incr  = ADDR_WIDTH'(1) << hsize_ip;
    // Start address is aligned down to the transfer size.
    assign w_req_addr  = addr_ip & ~(w_req_incr - ADDR_WIDTH'(1));
    // Wrap mask covers the n*2^size block; INCR bursts use an all-ones mask
    // so the same next-address formula degenerates to a plain increment.
    assign w_req_mask  = w_req_wrap ?
                         ((w_req_incr << burst_shift(hburst_ip)) - ADDR_WIDTH'(1)) :
                         {ADDR_WIDTH{1'b1}};

    // ------------------------------------------------------------------------
    // Address sequencing
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]   w_incr;
    logic [ADDR_WIDTH-1:0]   w_addr_next;

    assign w_incr      = ADDR_WIDTH'(1) << r_hsize;
    assign w_addr_next = (r_haddr & ~r_wrap_mask) |
                         ((r_haddr + w_incr) & r_wrap_mask);

    // ------------------------------------------------------------------------
    // Bus handshake qualifiers
    // ------------------------------------------------------------------------
    logic w_dphase;
    logic w_addr_accept;
    logic w_err_first;
    logic w_err_abrupt;
    logic w_rd_beat;
    logic w_last_addr;

    // A data phase of ours is in flight only in BURST and LAST.
    assign w_dphase      = (r_state == c_ST_BURST) || (r_state == c_ST_LAST);
    // In BURST a SEQ address is only taken when the overlapping data phase
    // is not signalling ERROR.
    assign w_addr_accept = HREADY && ((r_state == c_ST_ADDR) ||
                                      ((r_state == c_ST_BURST) && !HRSP));
    assign w_err_first   = w_dphase && HRSP && !HREADY;
    // ERROR seen without its first wait cycle: abort immediately.
    assign w_err_abrupt  = w_dphase && HRSP && HREADY;
    assign w_rd_beat     = w_dphase && HREADY && !HRSP && !r_hwrite;
    assign w_last_addr   = (r_beats_left == 5'd1);

    assign wdata_ack     = w_addr_accept && r_hwrite;

    // ------------------------------------------------------------------------
    // Write-data check bits: odd parity per byte lane
    // ------------------------------------------------------------------------
    logic [c_NUM_LANES-1:0] w_data_chk;

    genvar gi;
    generate
        for (gi = 0; gi < c_NUM_LANES; gi++) begin : g_chk
            assign w_data_chk[gi] = ~^data_ip[8*gi +: 8];
        end
    endgenerate

    // Control FSM: request capture, beat sequencing, completion and abort.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= c_ST_IDLE;
            r_haddr      <= '0;
            r_hwrite     <= 1'b0;
            r_hsize      <= 3'b000;
            r_hburst     <= 3'b000;
            r_wrap_mask  <= '0;
            r_beats_left <= 5'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (w_req_legal) begin
                            r_haddr      <= w_req_addr;
                            r_hwrite     <= hwrite_ip;
                            r_hsize      <= hsize_ip;
                            r_hburst     <= hburst_ip;
                            r_wrap_mask  <= w_req_mask;
                            r_beats_left <= burst_beats(hburst_ip);
                            r_state      <= c_ST_ADDR;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_ST_ADDR, c_ST_BURST: begin
                    if (w_err_first) begin
                        r_state <= c_ST_ERR;
                    end else if (w_err_abrupt) begin
                        r_state <= c_ST_IDLE;
                        r_err   <= 1'b1;
                    end else if (w_addr_accept) begin
                        r_beats_left <= r_beats_left - 5'd1;
                        if (w_last_addr) begin
                            r_state <= c_ST_LAST;
                        end else begin
                            r_state <= c_ST_BURST;
                            r_haddr <= w_addr_next;
                        end
                    end
                end
                c_ST_LAST: begin
                    if (w_err_first) begin
                        r_state <= c_ST_ERR;
                    end else if (w_err_abrupt) begin
                        r_state <= c_ST_IDLE;
                        r_err   <= 1'b1;
                    end else if (HREADY) begin
                        r_state <= c_ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                c_ST_ERR: begin
                    // Second ERROR cycle ends the transfer.
                    if (HREADY) begin
                        r_state <= c_ST_IDLE;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Data path: load write beat on address acceptance, capture read beats.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hwdata      <= '0;
            r_hwdatachk   <= {c_NUM_LANES{1'b1}};
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= w_rd_beat;
            if (w_rd_beat) begin
                r_rdata <= HRDATA;
            end
            if (wdata_ack) begin
                r_hwdata    <= data_ip;
                r_hwdatachk <= w_data_chk;
            end
        end
    end

    // Transfer type follows the registered state; BUSY is never issued.
    always_comb begin
        HTRANS = c_TRANS_IDLE;
        case (r_state)
            c_ST_ADDR:  HTRANS = c_TRANS_NONSEQ;
            c_ST_BURST: HTRANS = c_TRANS_SEQ;
            default:    HTRANS = c_TRANS_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign HADDR       = r_haddr;
    assign HWRITE      = r_hwrite;
    assign HSIZE       = r_hsize;
    assign HBURST      = r_hburst;
    assign HWDATA      = r_hwdata;
    assign HWDATACHK   = r_hwdatachk;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign busy        = (r_state != c_ST_IDLE);
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ahb_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_burst_master
// Description : Directed, self-checking bench for ahb_burst_master. Each task
//               drives one scenario and compares outputs cycle by cycle
//               against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_burst_master;

    localparam int c_AW = 20;
    localparam int c_DW = 32;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic              start;
    logic [c_AW-1:0]   addr_ip;
    logic [2:0]        hsize_ip;
    logic [2:0]        hburst_ip;
    logic              hwrite_ip;
    logic [c_DW-1:0]   data_ip;
    logic              HREADY;
    logic              HRSP;
    logic [c_DW-1:0]   HRDATA;
    logic [c_AW-1:0]   HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [c_DW-1:0]   HWDATA;
    logic [c_DW/8-1:0] HWDATACHK;
    logic              wdata_ack;
    logic [c_DW-1:0]   rdata;
    logic              rdata_valid;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int fails  = 0;

    ahb_burst_master #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .addr_ip(addr_ip),
        .hsize_ip(hsize_ip), .hburst_ip(hburst_ip), .hwrite_ip(hwrite_ip),
        .data_ip(data_ip), .HREADY(HREADY), .HRSP(HRSP), .HRDATA(HRDATA),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HWDATACHK(HWDATACHK),
        .wdata_ack(wdata_ack), .rdata(rdata), .rdata_valid(rdata_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 HCLK = ~HCLK;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        addr_ip   = '0;
        hsize_ip  = 3'b000;
        hburst_ip = 3'b000;
        hwrite_ip = 1'b0;
        data_ip   = '0;
        HREADY    = 1'b1;
        HRSP      = 1'b0;
        HRDATA    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        HRESET = 1'b1;
        step();
        step();
        checks++; if (HADDR !== 20'h0) begin fails++; $display("FAIL reset_haddr: got %h want 00000", HADDR); end
        checks++; if (HTRANS !== 2'b00) begin fails++; $display("FAIL reset_htrans: got %b want 00", HTRANS); end
        checks++; if ({HWRITE, HSIZE, HBURST} !== 7'h00) begin fails++; $display("FAIL reset_ctrl: got %b want 0000000", {HWRITE, HSIZE, HBURST}); end
        checks++; if (HWDATA !== 32'h0) begin fails++; $display("FAIL reset_hwdata: got %h want 0", HWDATA); end
        checks++; if (HWDATACHK !== 4'hF) begin fails++; $display("FAIL reset_hwdatachk: got %b want 1111", HWDATACHK); end
        checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if ({rdata_valid, busy, done, err} !== 4'b0000) begin fails++; $display("FAIL reset_status: got %b want 0000", {rdata_valid, busy, done, err}); end
        HRESET = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        start = 1'b1; addr_ip = 20'h00010; hsize_ip = 3'b010; hburst_ip = 3'b000;
        hwrite_ip = 1'b1; data_ip = 32'hA5A5_0001;
        step();                                   // cycle 1
        start = 1'b0;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 20'h00010) begin fails++; $display("FAIL single_nonseq: got %b/%h want 10/00010", HTRANS, HADDR); end
        checks++; if (HWRITE !== 1'b1 || HSIZE !== 3'b010 || HBURST !== 3'b000) begin fails++; $display("FAIL single_ctrl: got %b %b %b want 1 010 000", HWRITE, HSIZE, HBURST); end
        checks++; if (wdata_ack !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL single_ack: ack=%b busy=%b want 1 1", wdata_ack, busy); end
        step();                                   // cycle 2
        data_ip = 32'hFFFF_FFFF;                  // driver moves on after the ack
        checks++; if (HWDATA !== 32'hA5A5_0001 || HWDATACHK !== 4'b1110) begin fails++; $display("FAIL single_wdata: got %h/%b want a5a50001/1110", HWDATA, HWDATACHK); end
        checks++; if (HTRANS !== 2'b00 || wdata_ack !== 1'b0) begin fails++; $display("FAIL single_last: got %b ack=%b want 00 0", HTRANS, wdata_ack); end
        step();                                   // cycle 3
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL single_done: done=%b busy=%b want 1 0", done, busy); end
        step();                                   // cycle 4
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL single_done_pulse: done=%b want 0", done); end
    endtask

    task automatic test_incr4_read();
        logic [1:0]  et;
        logic [19:0] ea;
        logic        ev;
        start = 1'b1; addr_ip = 20'h00100; hsize_ip = 3'b010; hburst_ip = 3'b011;
        hwrite_ip = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            step();
            start  = 1'b0;
            HRDATA = 32'hD000_0000 + 32'(c);
            et = (c == 1) ? 2'b10 : (c <= 4) ? 2'b11 : 2'b00;
            ea = 20'h00100 + 20'(4 * (c - 1));
            ev = (c >= 3 && c <= 6);
            checks++; if (HTRANS !== et) begin fails++; $display("FAIL incr4_htrans c%0d: got %b want %b", c, HTRANS, et); end
            if (c <= 4) begin
                checks++; if (HADDR !== ea) begin fails++; $display("FAIL incr4_haddr c%0d: got %h want %h", c, HADDR, ea); end
            end
            checks++; if (rdata_valid !== ev) begin fails++; $display("FAIL incr4_rvalid c%0d: got %b want %b", c, rdata_valid, ev); end
            if (ev) begin
                checks++; if (rdata !== 32'hD000_0000 + 32'(c - 1)) begin fails++; $display("FAIL incr4_rdata c%0d: got %h want %h", c, rdata, 32'hD000_0000 + 32'(c - 1)); end
            end
            checks++; if (done !== (c == 6) || busy !== (c <= 5)) begin fails++; $display("FAIL incr4_status c%0d: done=%b busy=%b", c, done, busy); end
        end
        HRDATA = '0;
    endtask

    task automatic test_wrap8_write();
        logic [19:0] seq [8];
        logic [7:0]  par_tbl;
        logic [3:0]  echk;
        logic        ack_prev;
        int          acks;
        seq = '{20'h3C, 20'h20, 20'h24, 20'h28, 20'h2C, 20'h30, 20'h34, 20'h38};
        par_tbl = 8'b0110_1001;                   // ~^k for k = 0..7
        ack_prev = 1'b0;
        acks = 0;
        start = 1'b1; addr_ip = 20'h0003C; hsize_ip = 3'b010; hburst_ip = 3'b100;
        hwrite_ip = 1'b1; data_ip = 32'h1000_0000;
        for (int c = 1; c <= 10; c++) begin
            step();
            start = 1'b0;
            if (ack_prev) data_ip = data_ip + 32'd1;
            ack_prev = wdata_ack;
            if (wdata_ack === 1'b1) acks++;
            if (c <= 8) begin
                checks++; if (HTRANS !== ((c == 1) ? 2'b10 : 2'b11) || HADDR !== seq[c-1]) begin fails++; $display("FAIL wrap8_addr c%0d: got %b/%h want %h", c, HTRANS, HADDR, seq[c-1]); end
            end
            if (c >= 2 && c <= 9) begin
                echk = {3'b011, par_tbl[c-2]};
                checks++; if (HWDATA !== 32'h1000_0000 + 32'(c - 2) || HWDATACHK !== echk) begin fails++; $display("FAIL wrap8_wdata c%0d: got %h/%b want %h/%b", c, HWDATA, HWDATACHK, 32'h1000_0000 + 32'(c - 2), echk); end
            end
            checks++; if (done !== (c == 10)) begin fails++; $display("FAIL wrap8_done c%0d: got %b", c, done); end
        end
        checks++; if (acks != 8) begin fails++; $display("FAIL wrap8_acks: got %0d want 8", acks); end
    endtask

    task automatic test_wait_states();
        logic [1:0]  et [8];
        logic [19:0] ea [8];
        logic        eack [8];
        logic [31:0] ewd [8];
        logic        ack_prev;
        et   = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
        ea   = '{20'h200, 20'h204, 20'h208, 20'h208, 20'h208, 20'h20C, 20'h0, 20'h0};
        eack = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ewd  = '{32'h0, 32'h2000_0000, 32'h2000_0001, 32'h2000_0001, 32'h2000_0001,
                 32'h2000_0002, 32'h2000_0003, 32'h0};
        ack_prev = 1'b0;
        start = 1'b1; addr_ip = 20'h00200; hsize_ip = 3'b010; hburst_ip = 3'b011;
        hwrite_ip = 1'b1; data_ip = 32'h2000_0000;
        for (int c = 1; c <= 8; c++) begin
            step();
            start = 1'b0;
            if (ack_prev) data_ip = data_ip + 32'd1;
            HREADY = !(c == 3 || c == 4);
            #1;
            ack_prev = wdata_ack;
            checks++; if (HTRANS !== et[c-1]) begin fails++; $display("FAIL wait_htrans c%0d: got %b want %b", c, HTRANS, et[c-1]); end
            if (c <= 6) begin
                checks++; if (HADDR !== ea[c-1]) begin fails++; $display("FAIL wait_haddr c%0d: got %h want %h", c, HADDR, ea[c-1]); end
            end
            checks++; if (wdata_ack !== eack[c-1]) begin fails++; $display("FAIL wait_ack c%0d: got %b want %b", c, wdata_ack, eack[c-1]); end
            if (c >= 2 && c <= 7) begin
                checks++; if (HWDATA !== ewd[c-1]) begin fails++; $display("FAIL wait_hwdata c%0d: got %h want %h", c, HWDATA, ewd[c-1]); end
            end
            checks++; if (done !== (c == 8)) begin fails++; $display("FAIL wait_done c%0d: got %b", c, done); end
        end
        HREADY = 1'b1;
    endtask

    task automatic test_error();
        logic [1:0] et [8];
        int         rv_count;
        et = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        rv_count = 0;
        start = 1'b1; addr_ip = 20'h00300; hsize_ip = 3'b010; hburst_ip = 3'b101;
        hwrite_ip = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            start  = 1'b0;
            HRDATA = 32'hE000_0000 + 32'(c);
            HRSP   = (c == 3 || c == 4);
            HREADY = (c != 3);
            if (rdata_valid === 1'b1) rv_count++;
            checks++; if (HTRANS !== et[c-1]) begin fails++; $display("FAIL err_htrans c%0d: got %b want %b", c, HTRANS, et[c-1]); end
            if (c <= 3) begin
                checks++; if (HADDR !== 20'h00300 + 20'(4 * (c - 1))) begin fails++; $display("FAIL err_haddr c%0d: got %h", c, HADDR); end
            end
            if (c == 3) begin
                checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hE000_0002) begin fails++; $display("FAIL err_beat1 c%0d: valid=%b rdata=%h want 1 e0000002", c, rdata_valid, rdata); end
            end
            checks++; if (err !== (c == 5) || done !== 1'b0 || busy !== (c <= 4)) begin fails++; $display("FAIL err_status c%0d: err=%b done=%b busy=%b", c, err, done, busy); end
        end
        checks++; if (rv_count != 1) begin fails++; $display("FAIL err_rvalid_count: got %0d want 1", rv_count); end
        HRSP = 1'b0; HREADY = 1'b1; HRDATA = '0;
    endtask

    task automatic test_illegal();
        start = 1'b1; addr_ip = 20'h00800; hsize_ip = 3'b011; hburst_ip = 3'b000;
        hwrite_ip = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
            checks++; if (err !== (c == 1) || busy !== 1'b0 || done !== 1'b0 || HTRANS !== 2'b00) begin fails++; $display("FAIL illegal c%0d: err=%b busy=%b done=%b htrans=%b", c, err, busy, done, HTRANS); end
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; addr_ip = 20'h00400; hsize_ip = 3'b010; hburst_ip = 3'b111;
        hwrite_ip = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            start  = 1'b0;
            HRDATA = 32'h1111_0000 + 32'(c);
            checks++; if (HTRANS !== ((c == 1) ? 2'b10 : 2'b11) || HADDR !== 20'h00400 + 20'(4 * (c - 1))) begin fails++; $display("FAIL rstmid_addr c%0d: got %b/%h", c, HTRANS, HADDR); end
        end
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        checks++; if (HADDR !== 20'h0 || HTRANS !== 2'b00 || {HWRITE, HSIZE, HBURST} !== 7'h00) begin fails++; $display("FAIL rstmid_bus: got %h %b %b", HADDR, HTRANS, {HWRITE, HSIZE, HBURST}); end
        checks++; if (rdata !== 32'h0 || HWDATA !== 32'h0 || HWDATACHK !== 4'hF) begin fails++; $display("FAIL rstmid_data: rdata=%h hwdata=%h chk=%b", rdata, HWDATA, HWDATACHK); end
        checks++; if ({rdata_valid, busy, done, err} !== 4'b0000) begin fails++; $display("FAIL rstmid_status: got %b want 0000", {rdata_valid, busy, done, err}); end
        start = 1'b1; addr_ip = 20'h00ABE; hsize_ip = 3'b010; hburst_ip = 3'b000;
        hwrite_ip = 1'b0; HRDATA = '0;
        step();                                   // cycle 1
        start = 1'b0;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 20'h00ABC || HWRITE !== 1'b0 || HSIZE !== 3'b010) begin fails++; $display("FAIL rstmid_single_addr: got %b %h %b %b", HTRANS, HADDR, HWRITE, HSIZE); end
        step();                                   // cycle 2
        HRDATA = 32'hCAFE_F00D;
        checks++; if (HTRANS !== 2'b00 || busy !== 1'b1) begin fails++; $display("FAIL rstmid_single_last: got %b busy=%b", HTRANS, busy); end
        step();                                   // cycle 3
        checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hCAFE_F00D || done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL rstmid_single_done: v=%b rdata=%h done=%b err=%b", rdata_valid, rdata, done, err); end
        HRDATA = '0;
    endtask

    task automatic test_back_to_back();
        start = 1'b1; addr_ip = 20'h00500; hsize_ip = 3'b010; hburst_ip = 3'b000;
        hwrite_ip = 1'b1; data_ip = 32'h5555_AAAA;
        step();                                   // cycle 1: start held, must be ignored
        addr_ip = 20'h00600;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 20'h00500) begin fails++; $display("FAIL b2b_first: got %b/%h want 10/00500", HTRANS, HADDR); end
        step();                                   // cycle 2
        checks++; if (HTRANS !== 2'b00 || busy !== 1'b1 || HWDATA !== 32'h5555_AAAA) begin fails++; $display("FAIL b2b_ignore: got %b busy=%b wd=%h", HTRANS, busy, HWDATA); end
        step();                                   // cycle 3: idle again, new request
        checks++; if (done !== 1'b1 || busy !== 1'b0 || HTRANS !== 2'b00) begin fails++; $display("FAIL b2b_done: done=%b busy=%b htrans=%b", done, busy, HTRANS); end
        addr_ip = 20'h00700; hwrite_ip = 1'b0;
        step();                                   // cycle 4
        start = 1'b0;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 20'h00700 || HWRITE !== 1'b0) begin fails++; $display("FAIL b2b_second: got %b/%h w=%b want 10/00700 0", HTRANS, HADDR, HWRITE); end
        step();                                   // cycle 5
        HRDATA = 32'h7777_0007;
        checks++; if (HTRANS !== 2'b00 || done !== 1'b0) begin fails++; $display("FAIL b2b_second_last: got %b done=%b", HTRANS, done); end
        step();                                   // cycle 6
        checks++; if (rdata_valid !== 1'b1 || rdata !== 32'h7777_0007 || done !== 1'b1) begin fails++; $display("FAIL b2b_second_done: v=%b rdata=%h done=%b", rdata_valid, rdata, done); end
        HRDATA = '0;
    endtask

    initial begin
        HRESET = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_incr4_read();
        test_wrap8_write();
        test_wait_states();
        test_error();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
